count8_pwm: RTL and testbench

Downstream consumer of the 8-bit up-counter's `CNT` output. It turns the free-running count into a registered PWM waveform, a compare-match pulse and a wrap pulse. A double-buffered duty register is written through a ready/valid handshake and takes effect only on counter wrap, so a period is never glitched. The block sits directly after the counter and shares its clock and reset.

---
 rtl/count8_pkg.sv | 13 +
 rtl/count8_wrapdet.sv | 31 +++
 rtl/count8_pwm.sv | 96 +++++++++
 tb/tb_count8_pwm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/count8_pkg.sv
// Shared types and constants for the count8 PWM slice.
// Write-path state encoding plus the nominal counter width and terminal value.
package count8_pkg;

   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } wr_state_e;

endpackage

// File: rtl/count8_wrapdet.sv
// Remembers the previous counter sample and flags a true wrap (all-ones -> 0)
// and any change of the counter value since the previous edge.
module count8_wrapdet
   import count8_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         res,
   input  logic [W-1:0] cnt_i,
   output logic [W-1:0] cnt_q_o,
   output logic         wrap_o,
   output logic         chg_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_i;
      end
   end

   // A load to zero from any value other than all-ones is not a wrap.
   assign wrap_o  = (cnt_q == {W{1'b1}}) && (cnt_i == '0);
   assign chg_o   = (cnt_i != cnt_q);
   assign cnt_q_o = cnt_q;

endmodule

// File: rtl/count8_pwm.sv
// PWM generator driven by an external free-running counter. Duty writes are
// double-buffered and only take effect on a genuine counter wrap.
module count8_pwm
   import count8_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         res,
   input  logic [W-1:0] CNT,
   input  logic         pwm_en,
   input  logic         duty_wr,
   input  logic [W-1:0] duty_in,
   output logic         duty_rdy,
   output logic [W-1:0] duty_act,
   output logic         pwm_out,
   output logic         match,
   output logic         wrap
);

   // Handshake: a write transfers on a rising edge where duty_wr && duty_rdy.
   // duty_rdy does not depend on duty_wr; duty_wr while not ready is dropped.

   wr_state_e    state_q, state_d;
   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] duty_act_q, duty_act_d;
   logic         pwm_q, pwm_d;
   logic         match_q, match_d;
   logic         wrap_q, wrap_d;

   logic [W-1:0] cnt_prev;
   logic         wrap_s;
   logic         chg_s;

   count8_wrapdet #(.W(W)) u_wrapdet (
      .clk     (clk),
      .res     (res),
      .cnt_i   (CNT),
      .cnt_q_o (cnt_prev),
      .wrap_o  (wrap_s),
      .chg_o   (chg_s)
   );

   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      duty_act_d = duty_act_q;
      duty_rdy   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            duty_rdy = 1'b1;
            if (duty_wr) begin
               shadow_d = duty_in;
               state_d  = ST_PEND;
            end
         end
         ST_PEND: begin
            if (wrap_s) begin
               duty_act_d = shadow_q;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs use the duty in effect after this edge so a new duty
      // already governs the count-zero cycle.
      pwm_d   = pwm_en && (CNT < duty_act_d);
      match_d = (CNT == duty_act_d) && chg_s;
      wrap_d  = wrap_s;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= ST_IDLE;
         shadow_q   <= '0;
         duty_act_q <= '0;
         pwm_q      <= 1'b0;
         match_q    <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         duty_act_q <= duty_act_d;
         pwm_q      <= pwm_d;
         match_q    <= match_d;
         wrap_q     <= wrap_d;
      end
   end

   assign duty_act = duty_act_q;
   assign pwm_out  = pwm_q;
   assign match    = match_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_count8_pwm.sv
// Directed bench for count8_pwm: drives the counter value directly and checks
// duty handoff, PWM shape, match/wrap strobes and reset behaviour.
module tb_count8_pwm;

   logic       clk;
   logic       res;
   logic [7:0] CNT;
   logic       pwm_en;
   logic       duty_wr;
   logic [7:0] duty_in;
   logic       duty_rdy;
   logic [7:0] duty_act;
   logic       pwm_out;
   logic       match;
   logic       wrap;

   int n_vec;
   int n_err;

   count8_pwm #(.W(8)) dut (
      .clk      (clk),
      .res      (res),
      .CNT      (CNT),
      .pwm_en   (pwm_en),
      .duty_wr  (duty_wr),
      .duty_in  (duty_in),
      .duty_rdy (duty_rdy),
      .duty_act (duty_act),
      .pwm_out  (pwm_out),
      .match    (match),
      .wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a counter value, take one rising edge, settle 1 time unit past it.
   task automatic apply(input logic [7:0] c);
      CNT = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      res = 1'b1;
      apply(8'h00);
      apply(8'h00);
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b exp=1", duty_rdy); end
      n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL reset_act got=%h exp=00", duty_act); end
      n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
      n_vec++; if (match !== 1'b0) begin n_err++; $display("FAIL reset_match got=%b exp=0", match); end
      n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
      res = 1'b0;
   endtask

   // Duty 0: output constant low, one wrap and one match (count 0) per period.
   task automatic test_free_run;
      int nwrap;
      int nmatch;
      nwrap = 0;
      nmatch = 0;
      for (int i = 1; i <= 256; i++) begin
         apply(8'(i));
         nwrap += int'(wrap);
         nmatch += int'(match);
         n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL free_pwm cnt=%h got=%b exp=0", 8'(i), pwm_out); end
         n_vec++; if (wrap !== (i == 256)) begin n_err++; $display("FAIL free_wrap cnt=%h got=%b exp=%b", 8'(i), wrap, i == 256); end
      end
      n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL free_act got=%h exp=00", duty_act); end
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL free_rdy got=%b exp=1", duty_rdy); end
      n_vec++; if (nwrap !== 1) begin n_err++; $display("FAIL free_nwrap got=%0d exp=1", nwrap); end
      n_vec++; if (nmatch !== 1) begin n_err++; $display("FAIL free_nmatch got=%0d exp=1", nmatch); end
   endtask

   // Write 0x40 at count 0x10, a second write of 0x80 in PEND is ignored.
   task automatic test_write;
      int nmatch;
      for (int i = 1; i < 16; i++) apply(8'(i));
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL wr_rdy_pre got=%b exp=1", duty_rdy); end
      duty_wr = 1'b1;
      duty_in = 8'h40;
      apply(8'h10);
      duty_wr = 1'b0;
      n_vec++; if (duty_rdy !== 1'b0) begin n_err++; $display("FAIL wr_rdy_post got=%b exp=0", duty_rdy); end
      n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL wr_act_pend got=%h exp=00", duty_act); end
      for (int i = 17; i < 256; i++) begin
         duty_wr = (i == 32);
         duty_in = 8'h80;
         apply(8'(i));
         n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL wr_act_hold cnt=%h got=%h exp=00", 8'(i), duty_act); end
      end
      duty_wr = 1'b0;
      n_vec++; if (duty_rdy !== 1'b0) begin n_err++; $display("FAIL wr_rdy_ignored got=%b exp=0", duty_rdy); end
      apply(8'h00);
      n_vec++; if (duty_act !== 8'h40) begin n_err++; $display("FAIL wr_act_wrap got=%h exp=40", duty_act); end
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL wr_rdy_wrap got=%b exp=1", duty_rdy); end
      n_vec++; if (wrap !== 1'b1) begin n_err++; $display("FAIL wr_wrap got=%b exp=1", wrap); end
      n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL wr_pwm0 got=%b exp=1", pwm_out); end
      n_vec++; if (match !== 1'b0) begin n_err++; $display("FAIL wr_match0 got=%b exp=0", match); end
      nmatch = 0;
      for (int i = 1; i < 256; i++) begin
         apply(8'(i));
         nmatch += int'(match);
         n_vec++; if (pwm_out !== (i < 64)) begin n_err++; $display("FAIL wr_pwm cnt=%h got=%b exp=%b", 8'(i), pwm_out, i < 64); end
         n_vec++; if (match !== (i == 64)) begin n_err++; $display("FAIL wr_match cnt=%h got=%b exp=%b", 8'(i), match, i == 64); end
      end
      n_vec++; if (nmatch !== 1) begin n_err++; $display("FAIL wr_nmatch got=%0d exp=1", nmatch); end
      apply(8'h00);
      n_vec++; if (duty_act !== 8'h40) begin n_err++; $display("FAIL wr_act_2nd got=%h exp=40", duty_act); end
   endtask

   // A write accepted on the wrap edge waits for the following wrap.
   task automatic test_write_on_wrap;
      for (int i = 1; i < 256; i++) apply(8'(i));
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL ow_rdy_pre got=%b exp=1", duty_rdy); end
      duty_wr = 1'b1;
      duty_in = 8'h20;
      apply(8'h00);
      duty_wr = 1'b0;
      n_vec++; if (wrap !== 1'b1) begin n_err++; $display("FAIL ow_wrap got=%b exp=1", wrap); end
      n_vec++; if (duty_act !== 8'h40) begin n_err++; $display("FAIL ow_act_same got=%h exp=40", duty_act); end
      n_vec++; if (duty_rdy !== 1'b0) begin n_err++; $display("FAIL ow_rdy_post got=%b exp=0", duty_rdy); end
      for (int i = 1; i < 256; i++) begin
         apply(8'(i));
         n_vec++; if (pwm_out !== (i < 64)) begin n_err++; $display("FAIL ow_pwm cnt=%h got=%b exp=%b", 8'(i), pwm_out, i < 64); end
      end
      n_vec++; if (duty_act !== 8'h40) begin n_err++; $display("FAIL ow_act_hold got=%h exp=40", duty_act); end
      apply(8'h00);
      n_vec++; if (duty_act !== 8'h20) begin n_err++; $display("FAIL ow_act_next got=%h exp=20", duty_act); end
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL ow_rdy_next got=%b exp=1", duty_rdy); end
   endtask

   // Load to zero is not a wrap; held counter gives one match; pwm_en gating.
   task automatic test_load_hold;
      int nmatch;
      duty_wr = 1'b1;
      duty_in = 8'h30;
      apply(8'h01);
      duty_wr = 1'b0;
      for (int i = 2; i <= 17; i++) apply(8'(i));
      apply(8'h00);
      n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL ld_wrap got=%b exp=0", wrap); end
      n_vec++; if (duty_act !== 8'h20) begin n_err++; $display("FAIL ld_act got=%h exp=20", duty_act); end
      n_vec++; if (duty_rdy !== 1'b0) begin n_err++; $display("FAIL ld_rdy got=%b exp=0", duty_rdy); end
      n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL ld_pwm got=%b exp=1", pwm_out); end
      for (int i = 1; i <= 16; i++) apply(8'(i));
      pwm_en = 1'b0;
      apply(8'h10);
      n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL en_off_pwm got=%b exp=0", pwm_out); end
      n_vec++; if (match !== 1'b0) begin n_err++; $display("FAIL en_off_match got=%b exp=0", match); end
      pwm_en = 1'b1;
      apply(8'h10);
      n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL en_on_pwm got=%b exp=1", pwm_out); end
      for (int i = 17; i < 32; i++) apply(8'(i));
      nmatch = 0;
      for (int k = 0; k < 6; k++) begin
         apply(8'h20);
         nmatch += int'(match);
         n_vec++; if (match !== (k == 0)) begin n_err++; $display("FAIL hold_match k=%0d got=%b exp=%b", k, match, k == 0); end
         n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL hold_pwm k=%0d got=%b exp=0", k, pwm_out); end
         n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap k=%0d got=%b exp=0", k, wrap); end
      end
      n_vec++; if (nmatch !== 1) begin n_err++; $display("FAIL hold_nmatch got=%0d exp=1", nmatch); end
      for (int i = 33; i < 256; i++) apply(8'(i));
      apply(8'h00);
      n_vec++; if (duty_act !== 8'h30) begin n_err++; $display("FAIL ld_act_wrap got=%h exp=30", duty_act); end
   endtask

   // Reset while a 0xFF write is pending: immediate reset values, write lost.
   task automatic test_reset_pend;
      duty_wr = 1'b1;
      duty_in = 8'hFF;
      apply(8'h01);
      duty_wr = 1'b0;
      for (int i = 2; i <= 5; i++) apply(8'(i));
      n_vec++; if (duty_rdy !== 1'b0) begin n_err++; $display("FAIL rp_rdy_pend got=%b exp=0", duty_rdy); end
      #2;
      res = 1'b1;
      #1;
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL rp_rdy got=%b exp=1", duty_rdy); end
      n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL rp_act got=%h exp=00", duty_act); end
      n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rp_pwm got=%b exp=0", pwm_out); end
      n_vec++; if (match !== 1'b0) begin n_err++; $display("FAIL rp_match got=%b exp=0", match); end
      n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL rp_wrap got=%b exp=0", wrap); end
      apply(8'h00);
      res = 1'b0;
      for (int i = 1; i < 256; i++) apply(8'(i));
      apply(8'h00);
      n_vec++; if (wrap !== 1'b1) begin n_err++; $display("FAIL rp_wrap_after got=%b exp=1", wrap); end
      n_vec++; if (duty_act !== 8'h00) begin n_err++; $display("FAIL rp_act_after got=%h exp=00", duty_act); end
      n_vec++; if (duty_rdy !== 1'b1) begin n_err++; $display("FAIL rp_rdy_after got=%b exp=1", duty_rdy); end
      n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rp_pwm_after got=%b exp=0", pwm_out); end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      res     = 1'b1;
      CNT     = 8'h00;
      pwm_en  = 1'b1;
      duty_wr = 1'b0;
      duty_in = 8'h00;
      test_reset();
      test_free_run();
      test_write();
      test_write_on_wrap();
      test_load_hold();
      test_reset_pend();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
